pdo_frame_reader: RTL

//  Sequencer directly upstream of pdo_Cacher: drives DPRAMAddr and collects RAM_Q into a sample stream for the FFT input stage.
//  On Start, reads one frame per channel: left half (addr MSB=0), then right half (addr MSB=1).

---
 rtl/pdo_frame_reader_if.sv | 30 +++
 rtl/pdo_frame_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pdo_frame_reader_if.sv
// Output sample stream of pdo_frame_reader: ready/valid handshake plus frame markers.
// A sample transfers on every cycle where OutValid and OutReady are both high.
interface pdo_frame_reader_if #(
    parameter int bw_data = 16
);
    logic [bw_data-1:0] OutData;
    logic               OutValid;
    logic               OutReady;
    logic               OutSop;
    logic               OutEop;
    logic               OutChan;

    modport master (
        output OutData,
        output OutValid,
        output OutSop,
        output OutEop,
        output OutChan,
        input  OutReady
    );

    modport slave (
        input  OutData,
        input  OutValid,
        input  OutSop,
        input  OutEop,
        input  OutChan,
        output OutReady
    );
endinterface

// File: rtl/pdo_frame_reader.sv
// Frame read sequencer: walks {chan,index} through the DPRAM and streams RAM_Q out
// through a 2-entry skid FIFO with a same-cycle bypass when the FIFO is empty.
module pdo_frame_reader #(
    parameter int bw_dpram = 12,
    parameter int bw_data  = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Mono,
    output logic [bw_dpram-1:0]   DPRAMAddr,
    input  logic [bw_data-1:0]    RAM_Q,
    pdo_frame_reader_if.master    out_if,
    output logic                  Busy,
    output logic                  Done,
    output logic [1:0]            dbg_state_o,
    output logic [1:0]            dbg_fifo_count_o
);

    localparam int IW = bw_dpram - 1;
    localparam logic [IW-1:0] LAST_IDX = '1;

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("pdo_frame_reader supports RD_LAT == 1 only");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [bw_data-1:0] data;
        logic               sop;
        logic               eop;
        logic               chan;
    } entry_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                chan_q, chan_d;
    logic                mono_q, mono_d;
    logic                done_q, done_d;
    logic [bw_dpram-1:0] addr_q;

    // Read issued last cycle; its data is on RAM_Q this cycle with these tags.
    logic                inflight_q;
    logic                tag_sop_q, tag_eop_q, tag_chan_q;

    entry_t              fifo_q [2];
    logic                rd_ptr_q, wr_ptr_q;
    logic [1:0]          count_q;

    logic                fifo_valid;
    logic                out_valid;
    logic                pop;
    logic                fifo_pop;
    logic                push;
    logic [2:0]          occ;
    logic                issue;
    entry_t              bypass;
    entry_t              head;

    assign fifo_valid = (count_q != 2'd0);
    assign out_valid  = fifo_valid | inflight_q;
    assign pop        = out_valid & out_if.OutReady;
    assign fifo_pop   = pop & fifo_valid;
    // When the FIFO is empty an accepted sample is the bypassed RAM_Q and is never stored.
    assign push       = inflight_q & ~(pop & ~fifo_valid);

    // Occupancy after this cycle, excluding any read issued now.
    assign occ   = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (state_q == S_RUN) && (occ < 3'd2);

    assign DPRAMAddr = issue ? {chan_q, idx_q} : addr_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chan_d  = chan_q;
        mono_d  = mono_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    chan_d  = 1'b0;
                    mono_d  = Mono;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (idx_q == LAST_IDX) begin
                        if (!chan_q && !mono_q) begin
                            chan_d = 1'b1;
                            idx_d  = '0;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (occ == 3'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            chan_q     <= 1'b0;
            mono_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_sop_q  <= 1'b0;
            tag_eop_q  <= 1'b0;
            tag_chan_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            chan_q     <= chan_d;
            mono_q     <= mono_d;
            done_q     <= done_d;
            addr_q     <= DPRAMAddr;
            inflight_q <= issue;
            if (issue) begin
                tag_sop_q  <= (idx_q == '0);
                tag_eop_q  <= (idx_q == LAST_IDX);
                tag_chan_q <= chan_q;
            end
        end
    end

    assign bypass = '{data: RAM_Q, sop: tag_sop_q, eop: tag_eop_q, chan: tag_chan_q};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bypass;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    // Head is all-zero whenever nothing is valid, so flags need no extra gating.
    always_comb begin
        head = '0;
        if (fifo_valid) begin
            head = fifo_q[rd_ptr_q];
        end else if (inflight_q) begin
            head = bypass;
        end
    end

    assign out_if.OutValid = out_valid;
    assign out_if.OutData  = head.data;
    assign out_if.OutSop   = head.sop;
    assign out_if.OutEop   = head.eop;
    assign out_if.OutChan  = head.chan;

    assign Busy             = (state_q != S_IDLE);
    assign Done             = done_q;
    assign dbg_state_o      = state_q;
    assign dbg_fifo_count_o = count_q;

endmodule
